// File: rtl/mem_dados_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores on little-endian lanes,
// configurable access latency, and sticky alignment/range error reporting.
//
// state  | meaning
// OCIOSO | idle, accepts a request when req=1
// ESPERA | access in flight, counting down the remaining latency
// FIM    | completion cycle: pronto=1, store commit, load data capture
module mem_dados_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  EscreveMem,
    input  logic                  LeMem,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [DATA_WIDTH-1:0] Dados_escrita,
    input  logic [1:0]            tamanho,
    input  logic                  sem_sinal,
    output logic [DATA_WIDTH-1:0] Dados_leitura,
    output logic                  pronto,
    output logic                  ocupado,
    output logic                  erro_alinhamento,
    output logic                  erro_faixa
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam int         HI_BIT   = DEPTH_LOG2 + 2;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t estado_q, estado_d;

    logic [1:0]            cnt_q, cnt_d;
    logic                  ocupado_q, ocupado_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [DATA_WIDTH-1:0] dl_q, dl_d;
    logic                  ea_q, ea_d;
    logic                  ef_q, ef_d;

    logic                  aceita;
    logic                  fim_ativo;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  desalinhado;
    logic                  fora_faixa;
    logic                  op_ilegal;
    logic                  acesso_ok;
    logic                  mem_wr;
    logic [3:0]            lane_en;
    logic [3:0]            mem_we;
    logic [DATA_WIDTH-1:0] wr_lanes;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_val;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (req) begin
                    estado_d = (LATENCY == 1) ? FIM : ESPERA;
                end
            end
            ESPERA: begin
                if (cnt_q == 2'd1) begin
                    estado_d = FIM;
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A reset arriving in the FIM cycle suppresses both pronto and the commit.
    always_comb begin
        aceita    = 1'b0;
        fim_ativo = 1'b0;
        case (estado_q)
            OCIOSO:  aceita    = req;
            FIM:     fim_ativo = ~reset;
            default: ;
        endcase
    end

    // ---------------- request latch, counter, busy ----------------
    always_comb begin
        cnt_d     = cnt_q;
        ocupado_d = ocupado_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        uns_d     = uns_q;
        we_d      = we_q;
        re_d      = re_q;
        if (aceita) begin
            cnt_d     = CNT_INIT;
            ocupado_d = 1'b1;
            addr_d    = endereco;
            wdata_d   = Dados_escrita;
            size_d    = tamanho;
            uns_d     = sem_sinal;
            we_d      = EscreveMem;
            re_d      = LeMem;
        end else if (estado_q == ESPERA) begin
            cnt_d = cnt_q - 2'd1;
        end else if (estado_q == FIM) begin
            ocupado_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ocupado_q <= ocupado_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            re_q      <= re_d;
        end
    end

    // ---------------- access classification ----------------
    always_comb begin
        word_idx    = addr_q[DEPTH_LOG2+1:2];
        lane        = addr_q[1:0];
        desalinhado = (size_q == 2'b11) ||
                      ((size_q == 2'b01) && addr_q[0]) ||
                      ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
        fora_faixa  = |(addr_q >> HI_BIT);
        op_ilegal   = (we_q == re_q);
        acesso_ok   = ~desalinhado & ~fora_faixa & ~op_ilegal;
    end

    // ---------------- store path ----------------
    always_comb begin
        lane_en  = 4'b0000;
        wr_lanes = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en  = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        mem_wr = fim_ativo & acesso_ok & we_q;
        mem_we = lane_en & {4{mem_wr}};
    end

    // Array is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) begin
                mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // ---------------- load path ----------------
    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {{(DATA_WIDTH-8){1'b0}}, rd_byte}
                                      : {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            2'b01:   load_val = uns_q ? {{(DATA_WIDTH-16){1'b0}}, rd_half}
                                      : {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // ---------------- result and sticky error flags ----------------
    // Misalignment wins over range/illegal-op when both apply.
    always_comb begin
        dl_d = dl_q;
        ea_d = ea_q;
        ef_d = ef_q;
        if (fim_ativo) begin
            if (desalinhado) begin
                ea_d = 1'b1;
            end else if (fora_faixa || op_ilegal) begin
                ef_d = 1'b1;
            end else if (re_q) begin
                dl_d = load_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dl_q <= '0;
            ea_q <= 1'b0;
            ef_q <= 1'b0;
        end else begin
            dl_q <= dl_d;
            ea_q <= ea_d;
            ef_q <= ef_d;
        end
    end

    assign Dados_leitura    = dl_q;
    assign pronto           = fim_ativo;
    assign ocupado          = ocupado_q;
    assign erro_alinhamento = ea_q;
    assign erro_faixa       = ef_q;

endmodule

// File: tb/tb_mem_dados_ctrl.sv
// Scoreboard bench for mem_dados_ctrl: byte-addressed reference model, directed
// cases for lanes/extension/errors/reset abort, then randomized traffic.
module tb_mem_dados_ctrl;

    localparam int LAT = 3;
    localparam int DL  = 8;
    localparam int NW  = 1 << DL;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        EscreveMem = 1'b0;
    logic        LeMem = 1'b0;
    logic [31:0] endereco = '0;
    logic [31:0] Dados_escrita = '0;
    logic [1:0]  tamanho = '0;
    logic        sem_sinal = 1'b0;
    logic [31:0] Dados_leitura;
    logic        pronto;
    logic        ocupado;
    logic        erro_alinhamento;
    logic        erro_faixa;

    mem_dados_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH_LOG2(DL),
        .LATENCY   (LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .EscreveMem      (EscreveMem),
        .LeMem           (LeMem),
        .endereco        (endereco),
        .Dados_escrita   (Dados_escrita),
        .tamanho         (tamanho),
        .sem_sinal       (sem_sinal),
        .Dados_leitura   (Dados_leitura),
        .pronto          (pronto),
        .ocupado         (ocupado),
        .erro_alinhamento(erro_alinhamento),
        .erro_faixa      (erro_faixa)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] dl;
        logic        ea;
        logic        ef;
        int          acc;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  ref_mem [NW*4];
    logic [31:0] ref_dl = '0;
    logic        ref_ea = 1'b0;
    logic        ref_ef = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, one access applied at a time.
    task automatic model_op(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz, input logic uns);
        int          n;
        logic [31:0] v;
        logic        mis;
        logic        oor;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        oor = (a >= 32'(NW * 4));
        if (mis) begin
            ref_ea = 1'b1;
        end else if (oor || (we == re)) begin
            ref_ef = 1'b1;
        end else begin
            n = 1 << sz;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
                end
                ref_dl = v;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (ocupado === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: ocupado still %b after 50 cycles", ocupado);
    endtask

    // Issues one request; optionally pulses a conflicting store mid-access.
    task automatic issue(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz, input logic uns,
                         input logic noise, input logic [31:0] noise_a);
        exp_t e;
        wait_idle();
        EscreveMem    = we;
        LeMem         = re;
        endereco      = a;
        Dados_escrita = d;
        tamanho       = sz;
        sem_sinal     = uns;
        req           = 1'b1;
        @(posedge clock);
        #1;
        model_op(we, re, a, d, sz, uns);
        e.dl  = ref_dl;
        e.ea  = ref_ea;
        e.ef  = ref_ef;
        e.acc = cyc;
        sb.push_back(e);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            chk("ocupado_busy", {31'b0, ocupado}, 32'd1);
            if (k == 1 && noise) begin
                EscreveMem    = 1'b1;
                LeMem         = 1'b0;
                endereco      = noise_a;
                Dados_escrita = $urandom;
                tamanho       = 2'd2;
                req           = 1'b1;
            end else begin
                req           = 1'b0;
                endereco      = $urandom;
                Dados_escrita = $urandom;
            end
        end
        @(negedge clock);
        chk("ocupado_release", {31'b0, ocupado}, 32'd0);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_dados", Dados_leitura, 32'd0);
        chk("rst_pronto", {31'b0, pronto}, 32'd0);
        chk("rst_ocupado", {31'b0, ocupado}, 32'd0);
        chk("rst_erro_alin", {31'b0, erro_alinhamento}, 32'd0);
        chk("rst_erro_faixa", {31'b0, erro_faixa}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_zero_outputs();
        ref_dl = '0;
        ref_ea = 1'b0;
        ref_ef = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Store that gets cut off by reset asserted in cycle rst_k after acceptance.
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int rst_k);
        wait_idle();
        EscreveMem    = 1'b1;
        LeMem         = 1'b0;
        endereco      = a;
        Dados_escrita = d;
        tamanho       = 2'd2;
        sem_sinal     = 1'b0;
        req           = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= rst_k; k++) begin
            @(negedge clock);
            req = 1'b0;
            if (k == rst_k) reset = 1'b1;
        end
        @(posedge clock);
        #1;
        chk_zero_outputs();
        ref_dl = '0;
        ref_ea = 1'b0;
        ref_ef = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every pronto pops one expectation and checks latency, data and flags.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (pronto === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto: pronto=1 with no access outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.acc + 1), 32'(LAT));
                    @(posedge clock);
                    #1;
                    chk("dados_leitura", Dados_leitura, e.dl);
                    chk("erro_alinhamento", {31'b0, erro_alinhamento}, {31'b0, e.ea});
                    chk("erro_faixa", {31'b0, erro_faixa}, {31'b0, e.ef});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        we;
        logic        re;
        int          r;

        repeat (3) @(posedge clock);
        #1;
        chk_zero_outputs();
        @(negedge clock);
        reset = 1'b0;

        // Give every word a known value so later loads are fully defined.
        for (int w = 0; w < NW; w++) begin
            issue(1'b1, 1'b0, 32'(w * 4), $urandom, 2'd2, 1'b0, 1'b0, '0);
        end

        issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, '0);

        issue(1'b1, 1'b0, 32'h20, 32'h00000000, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h22, 32'hABCDEF80, 2'd0, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h22, 32'h0, 2'd0, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h22, 32'h0, 2'd0, 1'b1, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0, '0);

        issue(1'b1, 1'b0, 32'h04, 32'h11223344, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h06, 32'h1234BEEF, 2'd1, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h04, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h06, 32'h0, 2'd1, 1'b0, 1'b0, '0);

        // Conflicting store pulsed mid-access must be ignored.
        issue(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'h10);
        issue(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, '0);

        issue(1'b0, 1'b1, 32'h02, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b1, 1'b1, 32'h00, 32'h55555555, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b0, 32'h00, 32'h55555555, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b0, 1'b1, 32'h00, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        do_reset();

        // Misaligned and out of range together: only the alignment flag.
        issue(1'b0, 1'b1, 32'h402, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        issue(1'b1, 1'b0, 32'h00, 32'h0, 2'd3, 1'b0, 1'b0, '0);
        do_reset();

        abort_store(32'h08, 32'h12345678, 2);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 2'd2, 1'b0, 1'b0, '0);
        abort_store(32'h08, 32'h12345678, LAT);
        issue(1'b0, 1'b1, 32'h08, 32'h0, 2'd2, 1'b0, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 39) do_reset();
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 1) begin
                a = $urandom | 32'h00000400;
            end else if (r < 8) begin
                a = 32'($urandom_range(0, 63));
            end else begin
                a = 32'($urandom_range(0, NW * 4 - 1));
            end
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
                a = (sz == 2'd2) ? {a[31:2], 2'b00} : (sz == 2'd1) ? {a[31:1], 1'b0} : a;
            end
            r = $urandom_range(0, 15);
            if (r == 0) begin
                we = 1'b1;
                re = 1'b1;
            end else if (r == 1) begin
                we = 1'b0;
                re = 1'b0;
            end else begin
                we = r[0];
                re = ~r[0];
            end
            issue(we, re, a, $urandom, sz, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 63)));
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d accesses never completed", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
